// File: rtl/imem_fetch_arbiter.sv
// Single-port instruction memory owner: boot-time loader phase, then fair
// arbitration between IF fetches and loader writes with a 1-cycle fetch return.
//
// state   | meaning
// LOAD    | only the loader may access memory; ld_done moves to RUN
// RUN     | fetch and loader share memory, alternating under contention
module imem_fetch_arbiter #(
  parameter int DEPTH         = 101,
  parameter int AW            = 7,
  parameter bit BOOT_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic          if_err,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_done,
  output logic          ld_ready,
  output logic          ld_err,
  output logic [AW:0]   ld_count,
  output logic          running,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

  localparam state_t RESET_STATE = BOOT_ON_RESET ? ST_LOAD : ST_RUN;

  state_t state, state_nxt;
  logic   last_fetch;
  logic   pend_valid;
  logic   pend_err;
  logic   ld_acc;
  logic   ld_ok;
  logic   if_in_range;
  logic   unused_bits;

  assign unused_bits = ^if_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RESET_STATE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_LOAD && ld_done) state_nxt = ST_RUN;
  end

  always_comb begin
    running  = (state == ST_RUN);
    ld_ready = 1'b1;
    if_gnt   = 1'b0;
    if (state == ST_RUN) begin
      ld_ready = !if_req || last_fetch;
      if_gnt   = if_req && !(ld_valid && ld_ready);
    end
  end

  assign ld_acc      = ld_valid && ld_ready;
  assign ld_ok       = ld_acc && (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < 30'(DEPTH));
  assign if_in_range = if_addr[31:2] < 30'(DEPTH);

  // if_gnt and ld_acc are mutually exclusive, so at most one access per cycle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_ok) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr[AW+1:2];
      mem_wdata = ld_data;
    end else if (if_gnt && if_in_range) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[AW+1:2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_fetch <= 1'b0;
      pend_valid <= 1'b0;
      pend_err   <= 1'b0;
      ld_err     <= 1'b0;
      ld_count   <= '0;
    end else begin
      if (if_gnt)      last_fetch <= 1'b1;
      else if (ld_acc) last_fetch <= 1'b0;
      pend_valid <= if_gnt;
      pend_err   <= if_gnt && !if_in_range;
      ld_err     <= ld_acc && !ld_ok;
      if (ld_ok && ld_count != '1) ld_count <= ld_count + 1'b1;
    end
  end

  // A flush in the return cycle kills the fetch issued one cycle earlier
  assign if_valid = pend_valid && !if_flush;
  assign if_err   = if_valid && pend_err;
  assign if_instr = (pend_valid && !pend_err) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: memory model, per-cycle reference model compare,
// and directed scenarios with literal expectations.
module tb_imem_fetch_arbiter;
  localparam int DEPTH = 101;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_flush = 1'b0;
  logic          if_gnt;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic          if_err;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          ld_done = 1'b0;
  logic          ld_ready;
  logic          ld_err;
  logic [AW:0]   ld_count;
  logic          running;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  imem_fetch_arbiter #(.DEPTH(DEPTH), .AW(AW), .BOOT_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_instr(if_instr), .if_err(if_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .ld_ready(ld_ready), .ld_err(ld_err), .ld_count(ld_count), .running(running),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] ram [0:127];
  initial for (int i = 0; i < 128; i++) ram[i] = '0;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: memory contents seen by software plus arbitration history
  logic [31:0] golden [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) golden[i] = '0;
  bit m_run, m_last_fetch, p_v, p_err, m_lderr;
  int m_count;
  logic [31:0] p_instr;
  bit n_run, n_last_fetch, n_pv, n_perr, n_lderr, n_ok, w_do;
  int n_count, w_idx;
  logic [31:0] n_pinstr, w_data;
  int n_gnt = 0, n_we = 0, n_lderr_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      m_run = 1'b0; m_last_fetch = 1'b0; p_v = 1'b0; p_err = 1'b0;
      m_lderr = 1'b0; m_count = 0; p_instr = '0; n_ok = 1'b0;
      chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_ld_err", {31'b0, ld_err}, 32'd0);
      chk("rst_ld_count", {24'b0, ld_count}, 32'd0);
      chk("rst_running", {31'b0, running}, 32'd0);
    end else begin
      bit loader_can, fetch_gets, lacc, lgood, fin;
      int fidx, lidx;
      logic [31:0] e_addr;
      fidx = int'(if_addr[31:2]);
      lidx = int'(ld_addr[31:2]);
      fin  = (if_addr[31:2] < 30'(DEPTH));
      loader_can = !m_run || !if_req || m_last_fetch;
      fetch_gets = m_run && if_req && !(ld_valid && loader_can);
      lacc  = ld_valid && loader_can;
      lgood = lacc && ld_addr[1:0] == 2'b00 && (ld_addr[31:2] < 30'(DEPTH));
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, loader_can});
      chk("if_gnt", {31'b0, if_gnt}, {31'b0, fetch_gets});
      chk("mem_en", {31'b0, mem_en}, {31'b0, lgood || (fetch_gets && fin)});
      chk("mem_we", {31'b0, mem_we}, {31'b0, lgood});
      if (lgood || (fetch_gets && fin)) begin
        e_addr = lgood ? 32'(lidx % 128) : 32'(fidx % 128);
        chk("mem_addr", {25'b0, mem_addr}, e_addr);
      end
      if (lgood) chk("mem_wdata", mem_wdata, ld_data);
      chk("if_valid", {31'b0, if_valid}, {31'b0, p_v && !if_flush});
      if (p_v && !if_flush) begin
        chk("if_instr", if_instr, p_instr);
        chk("if_err", {31'b0, if_err}, {31'b0, p_err});
      end
      chk("ld_err", {31'b0, ld_err}, {31'b0, m_lderr});
      chk("ld_count", {24'b0, ld_count}, 32'(m_count));
      chk("running", {31'b0, running}, {31'b0, m_run});
      n_gnt       += int'(if_gnt);
      n_we        += int'(mem_en && mem_we);
      n_lderr_cnt += int'(ld_err);
      n_run        = m_run || ld_done;
      n_last_fetch = fetch_gets ? 1'b1 : (lacc ? 1'b0 : m_last_fetch);
      n_pv         = fetch_gets;
      n_perr       = fetch_gets && !fin;
      n_pinstr     = (fetch_gets && fin) ? golden[fidx] : 32'h0;
      n_lderr      = lacc && !lgood;
      n_count      = (lgood && m_count < 255) ? m_count + 1 : m_count;
      w_do = lgood; w_idx = lidx; w_data = ld_data;
      n_ok = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst && n_ok) begin
      m_run = n_run; m_last_fetch = n_last_fetch; p_v = n_pv; p_err = n_perr;
      p_instr = n_pinstr; m_lderr = n_lderr; m_count = n_count;
      if (w_do) golden[w_idx] = w_data;
    end
    n_ok = 1'b0;
  end

  task automatic drv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g0, w0, e0;
    @(negedge clk); @(negedge clk);
    drv; rst = 1'b1;
    // Boot load
    drv; if_req = 1'b1; if_addr = 32'h0;
    ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'hE3A00014;
    @(negedge clk);
    chk("load_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("load_ld_ready", {31'b0, ld_ready}, 32'd1);
    drv; ld_addr = 32'h4; ld_data = 32'hE3A01A01; ld_done = 1'b1;
    drv; ld_valid = 1'b0; ld_done = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("boot_count", {24'b0, ld_count}, 32'd2);
    chk("boot_running", {31'b0, running}, 32'd1);
    // Back-to-back fetch
    drv; if_req = 1'b1; if_addr = 32'h0;
    drv; if_addr = 32'h4;
    @(negedge clk);
    chk("fetch0_valid", {31'b0, if_valid}, 32'd1);
    chk("fetch0_instr", if_instr, 32'hE3A00014);
    drv; if_req = 1'b0;
    @(negedge clk);
    chk("fetch4_instr", if_instr, 32'hE3A01A01);
    drv;
    @(negedge clk);
    chk("idle_valid", {31'b0, if_valid}, 32'd0);
    // Contention
    drv; ld_valid = 1'b1; ld_addr = 32'h8; ld_data = 32'h11111111;
    drv; if_req = 1'b1; if_addr = 32'h0; ld_addr = 32'hC; ld_data = 32'h22222222;
    g0 = n_gnt; w0 = n_we;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_gnt", {31'b0, if_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      drv;
    end
    if_req = 1'b0; ld_addr = 32'h6;
    chk("alt_fetches", 32'(n_gnt - g0), 32'd2);
    chk("alt_writes", 32'(n_we - w0), 32'd2);
    // Bad loader writes
    e0 = n_lderr_cnt; w0 = n_we;
    drv; ld_addr = 32'h194;
    drv; ld_valid = 1'b0;
    drv; drv;
    chk("bad_ld_err", 32'(n_lderr_cnt - e0), 32'd2);
    chk("bad_ld_we", 32'(n_we - w0), 32'd0);
    chk("bad_ld_count", {24'b0, ld_count}, 32'd5);
    // Range edge and flush
    if_req = 1'b1; if_addr = 32'h190;
    drv; if_addr = 32'h194;
    @(negedge clk);
    chk("idx100_valid", {31'b0, if_valid}, 32'd1);
    chk("idx100_err", {31'b0, if_err}, 32'd0);
    drv; if_req = 1'b0;
    @(negedge clk);
    chk("idx101_instr", if_instr, 32'h0);
    chk("idx101_err", {31'b0, if_err}, 32'd1);
    drv; if_req = 1'b1; if_addr = 32'h8;
    drv; if_req = 1'b0; if_flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", {31'b0, if_valid}, 32'd0);
    drv; if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h0;
    drv; if_addr = 32'h4; if_flush = 1'b1;
    @(negedge clk);
    chk("flush2_valid", {31'b0, if_valid}, 32'd0);
    drv; if_flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", {31'b0, if_valid}, 32'd1);
    chk("post_flush_instr", if_instr, 32'hE3A01A01);
    // Reset during a fetch
    drv; if_req = 1'b1; if_addr = 32'hC;
    drv; if_req = 1'b0;
    chk("pre_rst_valid", {31'b0, if_valid}, 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_rst_running", {31'b0, running}, 32'd0);
    drv; rst = 1'b1; ld_done = 1'b1;
    drv; ld_done = 1'b0;
    @(negedge clk);
    chk("reboot_running", {31'b0, running}, 32'd1);
    drv; if_req = 1'b1; if_addr = 32'hC;
    drv; if_addr = 32'h8;
    @(negedge clk);
    chk("persist_c", if_instr, 32'h22222222);
    drv; if_req = 1'b0;
    @(negedge clk);
    chk("persist_8", if_instr, 32'h11111111);
    drv; drv;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
